// File: rtl/write_buffer_controller_pkg.sv
// Shared definitions for the result-write handshake: stall response codes
// (also used by the main controller) and the responder FSM state encoding.
package write_buffer_controller_pkg;

   localparam logic [1:0] STALL_WAIT  = 2'b00;
   localparam logic [1:0] STALL_ACK   = 2'b10;
   localparam logic [1:0] STALL_FAULT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PENDING = 2'b01,
      ST_ACK     = 2'b10,
      ST_FAULT   = 2'b11
   } wb_state_e;

   // Stall code presented while the FSM sits in a given state.
   function automatic logic [1:0] stall_code(input wb_state_e s);
      case (s)
         ST_ACK:   return STALL_ACK;
         ST_FAULT: return STALL_FAULT;
         default:  return STALL_WAIT;
      endcase
   endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Synchronous output FIFO with occupancy count and a registered read port.
// Writes into a full FIFO and reads from an empty FIFO are ignored; full and
// empty are taken from the count before any same-cycle update.
module psum_out_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   occupancy_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  wr_ok;
   logic                  rd_ok;

   assign full_o      = (count_q == (ADDR_WIDTH+1)'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign occupancy_o = count_q;
   assign rd_data_o   = rd_data_q;

   assign wr_ok = wr_en_i & ~full_o;
   assign rd_ok = rd_en_i & ~empty_o;

   // Pointers, count and read data register; pointers wrap modulo depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
         if (rd_ok) begin
            rd_ptr_q  <= rd_ptr_q + ADDR_WIDTH'(1);
            rd_data_q <= mem_q[rd_ptr_q];
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array write.
   // NOTE: the array has no reset; only pointers and count define validity,
   // which keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/write_buffer_controller.sv
// Responder side of the result-write handshake. A one-cycle write_req is
// captured into a hold register, pushed into the output FIFO once there is
// room, and answered on stall with accept, wait or a terminal fault.
module write_buffer_controller
   import write_buffer_controller_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_req,
   input  logic [DATA_WIDTH-1:0] result_in,
   output logic [1:0]            stall,
   input  logic                  out_ren,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_empty,
   output logic                  out_full,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic                  fault
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   wb_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            stall_q;
   logic                  fault_q;
   logic                  fifo_wr;

   assign stall = stall_q;
   assign fault = fault_q;

   psum_out_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (fifo_wr),
      .wr_data_i  (hold_q),
      .rd_en_i    (out_ren),
      .rd_data_o  (out_data),
      .empty_o    (out_empty),
      .full_o     (out_full),
      .occupancy_o(occupancy)
   );

   // Next-state, hold capture, timeout count and FIFO write strobe.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      fifo_wr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (write_req) begin
               hold_d  = result_in;
               cnt_d   = '0;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // A second request before the accept is a protocol error; the
            // held word is dropped rather than written.
            if (write_req) begin
               state_d = ST_FAULT;
            end else if (!out_full) begin
               fifo_wr = 1'b1;
               state_d = ST_ACK;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_FAULT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ACK: begin
            state_d = write_req ? ST_FAULT : ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, hold and counter registers; stall/fault registered from next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         stall_q <= STALL_WAIT;
         fault_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_code(state_d);
         fault_q <= (state_d == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_write_buffer_controller.sv
// Self-checking bench for write_buffer_controller: table-driven fill/wrap
// vectors plus hand-written handshake, backpressure, timeout, protocol-error
// and reset sequences. Accepted words go to a scoreboard queue and are
// compared when the bench reads them back out.
module tb_write_buffer_controller;
   import write_buffer_controller_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int TO    = 64;
   localparam int DEPTH = 16;
   localparam int LIMIT = 200;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write_req = 1'b0;
   logic [DW-1:0] result_in = '0;
   logic [1:0]    stall;
   logic          out_ren = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_empty;
   logic          out_full;
   logic [AW:0]   occupancy;
   logic          fault;

   write_buffer_controller #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .TIMEOUT   (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .write_req(write_req),
      .result_in(result_in),
      .stall    (stall),
      .out_ren  (out_ren),
      .out_data (out_data),
      .out_empty(out_empty),
      .out_full (out_full),
      .occupancy(occupancy),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   int            n_vec  = 0;
   int            n_miss = 0;
   logic [DW-1:0] sb[$];

   typedef struct {
      bit            is_wr;
      logic [DW-1:0] data;    // write data, or expected read data
      int            exp_occ;
      bit            exp_full;
      bit            exp_empty;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      write_req = 1'b0;
      out_ren   = 1'b0;
      step();
      check("rst_stall", stall, STALL_WAIT);
      check("rst_fault", fault, 0);
      check("rst_occ", occupancy, 0);
      check("rst_empty", out_empty, 1);
      check("rst_full", out_full, 0);
      check("rst_data", out_data, 0);
      step();
      reset = 1'b0;
      sb.delete();
   endtask

   // Issue one request and wait (bounded) for the accept; returns the number
   // of cycles spent after the request edge until stall showed accept.
   task automatic write_word(input logic [DW-1:0] val, output int waited);
      write_req = 1'b1;
      result_in = val;
      step();
      write_req = 1'b0;
      sb.push_back(val);
      waited = 0;
      while (stall !== STALL_ACK && waited < LIMIT) begin
         step();
         waited++;
      end
      check("wr_ack_seen", stall, STALL_ACK);
      step();
      check("wr_ack_once", stall, STALL_WAIT);
   endtask

   task automatic read_word(output logic [DW-1:0] got);
      out_ren = 1'b1;
      step();
      out_ren = 1'b0;
      got = out_data;
      if (sb.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL rd_sb: read data 0x%0h, expected no word pending", got);
      end else begin
         check("rd_data", got, sb.pop_front());
      end
   endtask

   function automatic vec_t mk_vec(input bit is_wr, input logic [DW-1:0] data, input int occ);
      vec_t v;
      v.is_wr     = is_wr;
      v.data      = data;
      v.exp_occ   = occ;
      v.exp_full  = (occ == DEPTH);
      v.exp_empty = (occ == 0);
      return v;
   endfunction

   initial begin
      #200us;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] got;
      int            w;
      int            n;
      int            occ;
      bit            ok;

      // ---------------- table: fill, wrap and drain ----------------
      occ = 0;
      for (int i = 1; i <= 16; i++) begin occ++; vecs.push_back(mk_vec(1'b1, DW'(i), occ)); end
      for (int i = 1; i <= 4; i++)  begin occ--; vecs.push_back(mk_vec(1'b0, DW'(i), occ)); end
      for (int i = 17; i <= 20; i++) begin occ++; vecs.push_back(mk_vec(1'b1, DW'(i), occ)); end
      for (int i = 5; i <= 20; i++) begin occ--; vecs.push_back(mk_vec(1'b0, DW'(i), occ)); end

      // ---------------- reset state ----------------
      apply_reset();

      // ---------------- single write, exact latency ----------------
      write_req = 1'b1;
      result_in = 16'h00A5;
      step();
      write_req = 1'b0;
      sb.push_back(16'h00A5);
      check("single_t1_stall", stall, STALL_WAIT);
      step();
      check("single_t2_stall", stall, STALL_ACK);
      check("single_occ", occupancy, 1);
      step();
      check("single_t3_stall", stall, STALL_WAIT);
      read_word(got);
      check("single_rdata", got, 16'h00A5);
      check("single_empty", out_empty, 1);

      // read while empty: ignored, data holds
      out_ren = 1'b1;
      step();
      out_ren = 1'b0;
      check("empty_rd_hold", out_data, 16'h00A5);
      check("empty_rd_occ", occupancy, 0);

      // read and write together on an empty FIFO: write lands, read ignored
      write_req = 1'b1;
      result_in = 16'h0C3C;
      step();
      write_req = 1'b0;
      out_ren   = 1'b1;
      sb.push_back(16'h0C3C);
      step();
      out_ren = 1'b0;
      check("rw_empty_ack", stall, STALL_ACK);
      check("rw_empty_occ", occupancy, 1);
      check("rw_empty_hold", out_data, 16'h00A5);
      step();
      read_word(got);

      // ---------------- table-driven fill and wrap ----------------
      apply_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_wr) begin
            write_word(vecs[i].data, w);
            check($sformatf("vec%0d_lat", i), w, 1);
         end else begin
            read_word(got);
            check($sformatf("vec%0d_rdata", i), got, vecs[i].data);
         end
         check($sformatf("vec%0d_occ", i), occupancy, vecs[i].exp_occ);
         check($sformatf("vec%0d_full", i), out_full, vecs[i].exp_full);
         check($sformatf("vec%0d_empty", i), out_empty, vecs[i].exp_empty);
      end

      // ---------------- backpressure recovery ----------------
      apply_reset();
      for (int i = 1; i <= 16; i++) write_word(DW'(i), w);
      check("bp_full", out_full, 1);
      write_req = 1'b1;
      result_in = 16'h1234;
      step();
      write_req = 1'b0;
      sb.push_back(16'h1234);
      ok = 1'b1;
      for (int c = 1; c < 10; c++) begin
         if (stall !== STALL_WAIT) ok = 1'b0;
         step();
      end
      check("bp_wait_9", ok, 1);
      check("bp_full_c10", out_full, 1);
      out_ren = 1'b1;
      step();
      out_ren = 1'b0;
      check("bp_rd_stall", stall, STALL_WAIT);
      check("bp_rd_occ", occupancy, 15);
      check("bp_rd_data", out_data, sb.pop_front());
      step();
      check("bp_ack", stall, STALL_ACK);
      check("bp_ack_occ", occupancy, 16);
      step();
      check("bp_ack_once", stall, STALL_WAIT);
      for (int i = 0; i < 16; i++) read_word(got);
      check("bp_last", got, 16'h1234);
      check("bp_drained", out_empty, 1);

      // ---------------- timeout fault ----------------
      apply_reset();
      for (int i = 1; i <= 16; i++) write_word(DW'(i), w);
      write_req = 1'b1;
      result_in = 16'hDEAD;
      step();
      write_req = 1'b0;
      check("to_c1_stall", stall, STALL_WAIT);
      n = 0;
      while (stall !== STALL_FAULT && n < LIMIT) begin
         step();
         n++;
      end
      check("to_cycles", n, TO);
      check("to_fault", fault, 1);
      ok = 1'b1;
      for (int c = 0; c < 100; c++) begin
         step();
         if (stall !== STALL_FAULT || fault !== 1'b1) ok = 1'b0;
      end
      check("to_hold_100", ok, 1);
      read_word(got);
      check("to_rd_occ", occupancy, 15);
      check("to_rd_stall", stall, STALL_FAULT);
      reset = 1'b1;
      #2;
      check("to_rst_stall", stall, STALL_WAIT);
      check("to_rst_fault", fault, 0);
      check("to_rst_occ", occupancy, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();

      // ---------------- protocol error ----------------
      write_req = 1'b1;
      result_in = 16'h5555;
      step();
      step();
      write_req = 1'b0;
      check("proto_stall", stall, STALL_FAULT);
      check("proto_fault", fault, 1);
      check("proto_occ", occupancy, 0);
      step();
      check("proto_occ_later", occupancy, 0);

      // ---------------- reset mid-operation ----------------
      apply_reset();
      write_word(16'h0101, w);
      write_req = 1'b1;
      result_in = 16'h7777;
      step();
      write_req = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("midrst_stall", stall, STALL_WAIT);
      check("midrst_occ", occupancy, 0);
      check("midrst_empty", out_empty, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      step();
      check("midrst_no_ack", stall, STALL_WAIT);
      check("midrst_occ_after", occupancy, 0);
      write_word(16'hBEEF, w);
      check("midrst_lat", w, 1);
      read_word(got);
      check("midrst_rdata", got, 16'hBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/write_buffer_controller.md
Name: write_buffer_controller

Overview:
Responder side of the main-controller result-write handshake. It accepts a one-cycle write request carrying a finished output-pixel result and stores it in an internal output FIFO. It answers on the 2-bit stall bus with an accept code (2'b10), a wait code (2'b00) or a terminal fault code (2'b11). The downstream output reader drains the FIFO through a simple read port.

Parameters:
DATA_WIDTH, 16, width of one result word
ADDR_WIDTH, 4, FIFO address bits; depth = 2**ADDR_WIDTH
TIMEOUT, 64, consecutive full cycles in PENDING before fault; must be >= 1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
write_req  in  1  one-cycle write request (main controller done)
result_in  in  DATA_WIDTH  result word, valid in the write_req cycle
stall  out  2  response code: 00 wait, 10 accepted, 11 fault
out_ren  in  1  downstream read strobe
out_data  out  DATA_WIDTH  read data, registered
out_empty  out  1  FIFO empty
out_full  out  1  FIFO full
occupancy  out  ADDR_WIDTH+1  words currently stored
fault  out  1  sticky fault flag, equals stall==2'b11

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state IDLE, stall 2'b00, out_data 0
  - out_empty 1, out_full 0, occupancy 0, fault 0
  - hold register 0, timeout counter 0
- Reset mid-transaction discards the held word and empties the FIFO. No accept is ever issued for that word.
- FSM states: IDLE, PENDING, ACK, FAULT. stall and fault are registered, decoded from the state: ACK gives 10, FAULT gives 11, all others give 00.
- IDLE:
  - On write_req=1, latch result_in into the hold register, clear the timeout counter and go to PENDING.
- PENDING:
  - If out_full=0: assert an internal FIFO write of the hold register this cycle, then go to ACK.
  - If out_full=1: stay in PENDING and increment the timeout counter.
  - When the counter reaches TIMEOUT-1 while the FIFO is still full, go to FAULT.
  - out_full is sampled before any same-cycle read. A simultaneous out_ren therefore does not admit the write; the write retries next cycle.
- ACK:
  - stall=2'b10 for exactly one cycle, then IDLE.
  - Latency: write_req sampled at edge T, stall=10 is visible in cycle T+2 when the FIFO is not full.
- FAULT: stall=2'b11 and fault=1 are held until reset.
- Protocol errors: write_req=1 in PENDING or ACK is an error and sends the FSM to FAULT at the next edge. The held word is not written.
- FIFO:
  - Synchronous FIFO of depth 2**ADDR_WIDTH; pointers are ADDR_WIDTH bits and wrap modulo depth.
  - occupancy is +1 on write only, -1 on read only, and unchanged when both happen.
  - out_full = (occupancy == depth); out_empty = (occupancy == 0).
- Read side:
  - out_ren with out_empty=0 pops one word; out_data updates at the next edge.
  - out_ren while out_empty=1 is ignored: no pointer move and out_data holds.
  - A read is allowed in any state, including FAULT, so the buffer can be drained for debug.
- Simultaneous read and write on an empty FIFO: the write lands and the read is ignored (empty was sampled before the write).

Decomposition:
- Shared package holds:
  - STALL_WAIT=2'b00, STALL_ACK=2'b10, STALL_FAULT=2'b11, which are also used by the main controller
  - the 2-bit state encodings IDLE/PENDING/ACK/FAULT
- One sub-module, psum_out_fifo: parameterised synchronous FIFO with occupancy, full, empty and a registered read port. The FSM, hold register and timeout counter stay in write_buffer_controller.

Test Plan:
- Single write: reset, write_req with result_in=16'h00A5 -> stall=00 in T+1, stall=10 in T+2 only, occupancy=1. Then out_ren -> out_data=16'h00A5, out_empty=1.
- Fill and wrap: 16 accepted writes of values 1..16 -> out_full=1, occupancy=16. Read 4, write 4 more (17..20), read all 16 -> data order 5..20, proving pointer wrap.
- Backpressure recovery: FIFO full, write_req of 16'h1234 -> stall stays 00. Assert out_ren for one cycle at the 10th full cycle -> write lands, stall=10 once, occupancy stays 16, last read word = 16'h1234.
- Timeout fault: FIFO full, write_req, no reads -> stall=11 and fault=1 after TIMEOUT cycles. Both stay set for 100 more cycles; reset clears them and occupancy returns to 0.
- Protocol error: write_req at T and again at T+1 -> FSM enters FAULT, stall=11, occupancy=0.
- Reset mid-operation: assert reset in the PENDING cycle -> stall=00 immediately (asynchronous), occupancy=0. A following write_req completes normally with stall=10.
